debounced_input_pio: RTL
========================

Name: debounced_input_pio

Overview:
- Parametrised Avalon-MM input PIO, successor to the plain button/switch read port.
- Adds a 2-flop synchroniser, a per-bit debounce filter, per-bit edge capture with selectable edge type, an interrupt mask register and a level IRQ output.
- Sits between board pushbuttons/switches and the Nios II system interconnect; one instance per input group.

Parameters:
- WIDTH, 2, number of input bits (1..32).
- DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronised bit must differ from the filtered value before the filtered value changes (>=1; 1 = no filtering).
- EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- in_port  in  WIDTH  asynchronous external inputs
- irq  out  1  level interrupt

Behaviour:
- Clocking and reset: one clock domain, reset synchronous and active-high. Reset clears sync1, sync2, filtered, all debounce counters, mask, capture and readdata to 0.
  - An input held high through reset therefore produces a rising edge after release.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit i, counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync2[i] == filtered[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: filtered[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and never changes filtered.
  - Latency: in_port change sampled at edge k reaches filtered at edge k+1+DEBOUNCE_CYCLES.
- Edge detect: computed from the value filtered is about to take.
  - rise = next & ~filtered; fall = ~next & filtered.
  - Capture set vector = rise / fall / rise|fall per EDGE_TYPE.
  - The capture bit is set on the same edge at which filtered changes.
- Register map (address, read, write):
  - 0: filtered data, zero-extended; write ignored.
  - 1: irq mask[WIDTH-1:0]; write loads writedata[WIDTH-1:0].
  - 2: edge capture; write 1 to clear each bit, 0 leaves it unchanged.
  - 3: raw sync2 value; write ignored.
- Writes take effect on the edge where chipselect=1 and write_n=0.
- Capture update: capture <= (capture & ~clr) | set. Set wins over a simultaneous write-1-clear on the same bit.
- Read: readdata <= zero-extended mux(address) every clk edge, independent of chipselect. Fixed read latency 1; bits 31:WIDTH always 0.
  - Read-back of a register written in the same cycle returns the old value; the new value is visible one cycle later.
- irq = |(capture & mask), derived combinationally from flops only.
  - Asserts the cycle after capture or mask sets; deasserts the cycle after clear or unmask.
- Reset mid-debounce: the counter is discarded and filtered returns to 0; no capture is generated by reset itself.

Test Plan:
- Reset, WIDTH=2, DEBOUNCE_CYCLES=4, in_port=2'b00 -> after reset, reads of addresses 0..3 all return 32'h0; irq=0.
- Clean rise: in_port[0] 0->1, held -> address 0 reads 1 exactly 1+4 edges after sampling, not earlier.
  - Address 2 reads 32'h1; with mask=32'h1 written first, irq=1 the cycle after the capture sets.
- Glitch: in_port[1] high for 3 cycles, then low -> address 0 stays 0 and capture stays 0. A 4-cycle pulse does set filtered[1] and capture[1].
- Clear race: write 32'h1 to address 2 on the same edge that a new rising edge sets bit 0 -> capture bit 0 remains 1; a later write-1 with no edge clears it and irq drops next cycle.
- EDGE_TYPE=1 and EDGE_TYPE=2 builds: press and release bit 0 -> capture sets only on release (type 1), on both press and release (type 2).
- Reset asserted mid-count: assert reset 2 cycles into a debounce -> filtered=0 and capture=0. With the input still high after release, filtered rises 1+4 edges later and capture sets.

Source files
------------

// File: rtl/debounced_input_pio_if.sv
// Avalon-MM slave bus bundle for debounced_input_pio.
// The interconnect drives the master side; the PIO sits on the slave side.
interface debounced_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/debounced_input_pio.sv
// Avalon-MM input PIO: 2-flop synchroniser, per-bit debounce filter,
// selectable edge capture with write-1-clear, interrupt mask and level IRQ.
module debounced_input_pio #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    debounced_input_pio_if.slave  avs,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_MASK = 2'd1,
        REG_EDGE = 2'd2,
        REG_RAW  = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] rise, fall, set_vec, clr_vec;
    logic             wr_en;
    reg_addr_e        reg_sel;
    logic             unused_wdata;

    assign wr_en        = avs.chipselect && !avs.write_n;
    assign reg_sel      = reg_addr_e'(avs.address);
    assign unused_wdata = ^avs.writedata;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Edges come from the value filtered is about to take, so capture lands with the change.
    always_comb begin
        rise = filt_d & ~filt_q;
        fall = ~filt_d & filt_q;
        if (EDGE_TYPE == 0)      set_vec = rise;
        else if (EDGE_TYPE == 1) set_vec = fall;
        else                     set_vec = rise | fall;

        clr_vec = (wr_en && reg_sel == REG_EDGE) ? avs.writedata[WIDTH-1:0] : '0;
        mask_d  = (wr_en && reg_sel == REG_MASK) ? avs.writedata[WIDTH-1:0] : mask_q;
        cap_d   = (cap_q & ~clr_vec) | set_vec;

        readdata_d = '0;
        case (reg_sel)
            REG_DATA: readdata_d[WIDTH-1:0] = filt_q;
            REG_MASK: readdata_d[WIDTH-1:0] = mask_q;
            REG_EDGE: readdata_d[WIDTH-1:0] = cap_q;
            REG_RAW:  readdata_d[WIDTH-1:0] = sync2_q;
            default:  readdata_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = |(cap_q & mask_q);
endmodule
